fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage of the five-stage pipeline and the producer side of the fetch/decode pipeline register. It owns the program counter and issues instruction-memory reads. It presents each returned instruction with its PC+4 to the fetch register, together with that register's enable and flush controls. Branch/jump redirects from later stages and hazard-unit stalls are resolved here, including redirects that arrive while an instruction-memory request is still outstanding.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory returns data for `imemaddr` this cycle.
- imemload  in  32  instruction word, valid when `ihit`=1.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address; must stay stable until `ihit`.
- stall  in  1  hazard unit holds fetch and the fetch register.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_pc  in  32  redirect target.
- fetch_imemload  out  32  instruction to the fetch register (passthrough of `imemload`).
- fetch_pc_4  out  32  PC+4 of that instruction.
- EN  out  1  fetch register load enable.
- flush  out  1  fetch register clear.
- fetch_halted  out  1  fetch stopped on a HALT opcode (see Configuration).

## Operation
- State: `pc[31:0]`, `pending_pc[31:0]`, FSM {RUN, DRAIN, HALTED}.
- Reset:
  - pc=PC_INIT, pending_pc=0, state=RUN.
  - While nRST=0, outputs are forced: imemREN=0, EN=0, flush=0, fetch_halted=0.
  - imemaddr=PC_INIT.
- Outputs from state:
  - imemaddr=pc, fetch_imemload=imemload, fetch_pc_4=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC).
  - imemREN=1 in RUN and DRAIN, 0 in HALTED.
- RUN, priority redirect > stall > normal:
  - redirect & ihit: flush=1, EN=0; pc<=redirect_pc; stay RUN.
  - redirect & !ihit: flush=1, EN=0; pending_pc<=redirect_pc; go DRAIN.
  - !redirect & ihit & stall: EN=0, flush=0; pc holds; the same address is re-requested next cycle.
  - !redirect & ihit & !stall: EN=1; pc<=pc+4.
  - !redirect & !ihit: EN=0, flush=0; pc holds.
- DRAIN (old request cannot be aborted):
  - imemaddr stays at the old pc and EN=0 throughout.
  - redirect: flush=1; pending_pc<=redirect_pc (the newest redirect wins).
  - ihit: returned data is discarded; pc<=pending_pc; go RUN.
    - If redirect is also high that cycle, pc<=redirect_pc instead.
  - stall is ignored.
- HALTED (only with FETCH_HALT_EN):
  - imemREN=0, EN=0, fetch_halted=1.
  - redirect: flush=1; pc<=redirect_pc; go RUN; fetch_halted clears next cycle.
- redirect_pc[1:0] is ignored; the PC is loaded with bits [1:0]=2'b00.

## Timing
- ihit to EN/fetch_imemload/fetch_pc_4: combinational, same cycle; the fetch register captures at the next edge.
- Steady state with ihit=1 every cycle: one instruction per cycle, pc advancing by 4.
- flush is a single-cycle pulse in every cycle redirect=1, and EN=0 in any cycle flush=1.
- Redirect to first fetch of the target:
  - 1 cycle in RUN.
  - In DRAIN: the remaining miss latency plus 1 cycle.
- Reset mid-DRAIN discards pending_pc; fetch restarts at PC_INIT.

## Configuration
- FETCH_HALT_EN defined:
  - A HALT is recognised in RUN when ihit=1, !redirect, !stall and imemload[31:26]=6'b111111.
  - It is passed with EN=1 and pc<=pc+4, and the FSM goes to HALTED.
- FETCH_HALT_EN undefined:
  - The HALT opcode is fetched like any other instruction.
  - HALTED is unreachable and fetch_halted is tied to 0.

## Test plan
- Reset, PC_INIT=32'h0000_0040, ihit=1 every cycle: imemaddr sequence 0x40, 0x44, 0x48; EN=1 each cycle; fetch_pc_4 sequence 0x44, 0x48, 0x4C.
- Stall for 2 cycles at pc=0x48 with ihit=1: EN=0 both cycles; imemaddr stays 0x48; the next cycle gives EN=1 with fetch_pc_4=0x4C.
- Redirect to 0x200 with ihit=1 in RUN: flush=1, EN=0; next imemaddr=0x200.
- Redirect to 0x300 at pc=0x80 with ihit=0, then a second redirect to 0x400 with ihit=0, then ihit=1 after 3 cycles:
  - imemaddr stays 0x80 throughout DRAIN; flush pulses twice; no EN.
  - Next imemaddr=0x400.
- With FETCH_HALT_EN, fetch 32'hFC00_0000 at 0x10:
  - EN=1 with fetch_pc_4=0x14, then fetch_halted=1 and imemREN=0.
  - A later redirect to 0x0 resumes fetch at 0x0.
  - Without the macro: EN=1 and fetch continues at 0x14.
- Assert nRST low during DRAIN at pc=0x80: outputs are forced to their reset values at once; after release imemaddr=PC_INIT and state=RUN.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory reads, drives the fetch/decode register.
// Optional HALT detection is compiled in with `define FETCH_HALT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_imemload,
  output logic [31:0] fetch_pc_4,
  output logic        EN,
  output logic        flush,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pending_pc, pending_pc_nxt;
  logic        en_c;
  logic        flush_c;

  // Branch targets are word-aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

`ifdef FETCH_HALT_EN
  localparam logic [5:0] HALT_OP = 6'b111111;
  logic halt_c;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      pending_pc <= 32'h0000_0000;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pending_pc <= pending_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pending_pc_nxt = pending_pc;
    en_c           = 1'b0;
    flush_c        = 1'b0;
`ifdef FETCH_HALT_EN
    halt_c         = 1'b0;
`endif
    case (state)
      RUN: begin
        if (redirect) begin
          flush_c = 1'b1;
          if (ihit) begin
            pc_nxt = align_pc(redirect_pc);
          end else begin
            // The in-flight read cannot be cancelled; park the target until it returns.
            pending_pc_nxt = align_pc(redirect_pc);
            state_nxt      = DRAIN;
          end
        end else if (ihit && !stall) begin
          en_c   = 1'b1;
          pc_nxt = pc + 32'd4;
`ifdef FETCH_HALT_EN
          if (imemload[31:26] == HALT_OP) begin
            state_nxt = HALTED;
          end
`endif
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush_c        = 1'b1;
          pending_pc_nxt = align_pc(redirect_pc);
        end
        if (ihit) begin
          pc_nxt    = redirect ? align_pc(redirect_pc) : pending_pc;
          state_nxt = RUN;
        end
      end
      HALTED: begin
`ifdef FETCH_HALT_EN
        halt_c = 1'b1;
        if (redirect) begin
          flush_c   = 1'b1;
          pc_nxt    = align_pc(redirect_pc);
          state_nxt = RUN;
        end
`else
        state_nxt = RUN;
`endif
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign imemaddr       = pc;
  assign fetch_imemload = imemload;
  assign fetch_pc_4     = pc + 32'd4;
  assign imemREN        = nRST & (state != HALTED);
  assign EN             = nRST & en_c;
  assign flush          = nRST & flush_c;
`ifdef FETCH_HALT_EN
  assign fetch_halted   = nRST & halt_c;
`else
  assign fetch_halted   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors, expected outputs queued by the driver.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_imemload;
  logic [31:0] fetch_pc_4;
  logic        EN;
  logic        flush;
  logic        fetch_halted;

  fetch_stage #(.PC_INIT(32'h0000_0040)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_imemload(fetch_imemload), .fetch_pc_4(fetch_pc_4),
    .EN(EN), .flush(flush), .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ren;
    logic        en;
    logic        fl;
    logic        halt;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] load;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   step_no = 0;
  bit   stim_done = 0;

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic cyc(input logic rst_n_i, input logic ih, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic [31:0] load,
                     input logic [31:0] e_addr, input logic e_ren, input logic e_en,
                     input logic e_fl, input logic e_halt);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST        = rst_n_i;
    ihit        = ih;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imemload    = load;
    e.ren  = e_ren;
    e.en   = e_en;
    e.fl   = e_fl;
    e.halt = e_halt;
    e.addr = e_addr;
    e.pc4  = e_addr + 32'd4;
    e.load = load;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation.
  always @(negedge CLK) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{ren: imemREN, en: EN, fl: flush, halt: fetch_halted,
            addr: imemaddr, pc4: fetch_pc_4, load: fetch_imemload};
      n_vec++;
      step_no++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got ren=%b en=%b flush=%b halt=%b addr=%h pc4=%h load=%h, want ren=%b en=%b flush=%b halt=%b addr=%h pc4=%h load=%h",
                 step_no, a.ren, a.en, a.fl, a.halt, a.addr, a.pc4, a.load,
                 e.ren, e.en, e.fl, e.halt, e.addr, e.pc4, e.load);
      end
    end
  end

  initial begin
    //   nrst ih st rd rpc           load          addr          ren en fl halt
    cyc(0, 1, 0, 0, 32'h0,        32'h1111_0000, 32'h0000_0040, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0001, 32'h0000_0040, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0002, 32'h0000_0044, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 32'h0,        32'h1111_0003, 32'h0000_0048, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 32'h0,        32'h1111_0004, 32'h0000_0048, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0005, 32'h0000_0048, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 32'h0000_0200, 32'h1111_0006, 32'h0000_004C, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0007, 32'h0000_0200, 1, 1, 0, 0);
    // Misaligned target: low bits dropped.
    cyc(1, 1, 0, 1, 32'h0000_0083, 32'h1111_0008, 32'h0000_0204, 1, 0, 1, 0);
    // Redirect on a miss, re-redirect while draining, then the old read returns.
    cyc(1, 0, 0, 1, 32'h0000_0300, 32'h1111_0009, 32'h0000_0080, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 32'h0000_0400, 32'h1111_000A, 32'h0000_0080, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 32'h0,        32'h1111_000B, 32'h0000_0080, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h0,        32'h1111_000C, 32'h0000_0080, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_000D, 32'h0000_0080, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_000E, 32'h0000_0400, 1, 1, 0, 0);
    // Drain with stall (ignored) and a redirect coinciding with the returning hit.
    cyc(1, 0, 0, 1, 32'h0000_0500, 32'h1111_000F, 32'h0000_0404, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 32'h0,        32'h1111_0010, 32'h0000_0404, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 32'h0000_0600, 32'h1111_0011, 32'h0000_0404, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0012, 32'h0000_0600, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 32'h0,        32'h1111_0013, 32'h0000_0604, 1, 0, 0, 0);
    // PC+4 wrap at the top of the address space.
    cyc(1, 1, 0, 1, 32'hFFFF_FFFC, 32'h1111_0014, 32'h0000_0604, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0015, 32'hFFFF_FFFC, 1, 1, 0, 0);
    // HALT opcode at 0x10.
    cyc(1, 1, 0, 1, 32'h0000_0010, 32'h1111_0016, 32'h0000_0000, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'hFC00_0000, 32'h0000_0010, 1, 1, 0, 0);
`ifdef FETCH_HALT_EN
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0017, 32'h0000_0014, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 32'h0000_0000, 32'h1111_0018, 32'h0000_0014, 0, 0, 1, 1);
`else
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0017, 32'h0000_0014, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 32'h0000_0000, 32'h1111_0018, 32'h0000_0018, 1, 0, 1, 0);
`endif
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_0019, 32'h0000_0000, 1, 1, 0, 0);
    // Reset asserted mid-drain.
    cyc(1, 1, 0, 1, 32'h0000_0080, 32'h1111_001A, 32'h0000_0004, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 32'h0000_0300, 32'h1111_001B, 32'h0000_0080, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 32'h0,        32'h1111_001C, 32'h0000_0080, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h0000_0700, 32'h1111_001D, 32'h0000_0040, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_001E, 32'h0000_0040, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 32'h0,        32'h1111_001F, 32'h0000_0044, 1, 1, 0, 0);
    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    while ((!stim_done || exp_q.size() > 0) && guard < 1000) begin
      @(posedge CLK);
      guard++;
    end
    if (exp_q.size() > 0 || !stim_done) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
